msd_seq_core: RTL and testbench

// Parametrised sequential multiply / divide / square-root engine. Successor of the fixed 16-bit MSD unit.

---
 rtl/msd_pkg.sv | 24 ++
 rtl/msd_seq_core_if.sv | 26 ++
 rtl/msd_sign_fix.sv | 10 +
 rtl/msd_seq_core.sv | 225 ++++++++++++++++++++++
 tb/tb_msd_seq_core.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/msd_pkg.sv
// Shared types for the sequential multiply/divide/square-root engine.
package msd_pkg;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_DIV  = 2'b01,
        OP_SQRT = 2'b10,
        OP_RSVD = 2'b11
    } opcode_t;

    typedef enum logic [2:0] {
        StIdle,
        StWaitX,
        StWaitY,
        StCalc,
        StDone
    } state_t;

    // SQRT retires two radicand bits per iteration, MUL/DIV one.
    function automatic int unsigned iter_count(opcode_t op, int unsigned width);
        return (op == OP_SQRT) ? width / 2 : width;
    endfunction

endpackage

// File: rtl/msd_seq_core_if.sv
// Operand-entry and result bus of the MSD engine.
interface msd_seq_core_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic             load;
    logic [1:0]       opcode;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] residue;
    logic             ready;
    logic             error;
    logic             busy;
    logic             load_x;
    logic             load_y;

    modport master (
        output start, load, opcode, data_in,
        input  result, residue, ready, error, busy, load_x, load_y
    );

    modport slave (
        input  start, load, opcode, data_in,
        output result, residue, ready, error, busy, load_x, load_y
    );
endinterface

// File: rtl/msd_sign_fix.sv
// Conditional two's-complement negate; doubles as abs() when negate is the sign bit.
module msd_sign_fix #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);
    assign result = negate ? ((~value) + WIDTH'(1)) : value;
endmodule

// File: rtl/msd_seq_core.sv
// Sequential MUL/DIV/SQRT engine: magnitude datapath, one result bit per CALC cycle,
// signs restored on the final iteration so outputs are registered on entry to DONE.
module msd_seq_core
    import msd_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter bit          SIGNED = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    msd_seq_core_if.slave  bus
);
    localparam int unsigned W2   = 2 * WIDTH;
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

    state_t            state_q, state_d;
    opcode_t           op_q, op_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [W2-1:0]     acc_q, acc_d, acc_it;
    logic [WIDTH-1:0]  opa_q, opa_d, opa_it;
    logic              x_neg_q, x_neg_d, res_neg_q, res_neg_d, rem_neg_q, rem_neg_d;
    logic              ovf_q, ovf_d;
    logic [WIDTH-1:0]  result_q, result_d, residue_q, residue_d;
    logic              ready_q, ready_d, error_q, error_d;

    logic              in_neg;
    logic [WIDTH-1:0]  in_mag, quo_fix, rem_fix;
    logic [W2-1:0]     prod_fix;
    logic [WIDTH:0]    mul_sum, div_sh;
    logic [WIDTH+1:0]  sq_sh, sq_trial;
    logic              div_ge, sq_ge;

    assign in_neg = SIGNED && bus.data_in[WIDTH-1];

    msd_sign_fix #(.WIDTH(WIDTH)) u_abs_in (
        .value (bus.data_in),
        .negate(in_neg),
        .result(in_mag)
    );
    msd_sign_fix #(.WIDTH(W2)) u_fix_prod (
        .value (acc_it),
        .negate(res_neg_q),
        .result(prod_fix)
    );
    msd_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
        .value (acc_it[WIDTH-1:0]),
        .negate(res_neg_q),
        .result(quo_fix)
    );
    msd_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
        .value (acc_it[W2-1:WIDTH]),
        .negate(rem_neg_q),
        .result(rem_fix)
    );

    // One iteration. acc holds {hi, lo}: MUL {product hi, multiplier},
    // DIV {remainder, dividend/quotient}, SQRT {remainder, radicand}; opa is
    // multiplicand, divisor or partial root.
    always_comb begin
        acc_it   = acc_q;
        opa_it   = opa_q;
        mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : '0);
        div_sh   = acc_q[W2-1:WIDTH-1];
        div_ge   = div_sh >= {1'b0, opa_q};
        sq_sh    = acc_q[W2-1:WIDTH-2];
        sq_trial = {opa_q, 2'b01};
        sq_ge    = sq_sh >= sq_trial;
        case (op_q)
            OP_MUL:  acc_it = {mul_sum, acc_q[WIDTH-1:1]};
            OP_DIV:  acc_it = {div_ge ? WIDTH'(div_sh - {1'b0, opa_q}) : div_sh[WIDTH-1:0],
                               acc_q[WIDTH-2:0], div_ge};
            OP_SQRT: begin
                acc_it = {sq_ge ? WIDTH'(sq_sh - sq_trial) : sq_sh[WIDTH-1:0],
                          acc_q[WIDTH-3:0], 2'b00};
                opa_it = {opa_q[WIDTH-2:0], sq_ge};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opa_d     = opa_q;
        x_neg_d   = x_neg_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        ovf_d     = ovf_q;
        result_d  = result_q;
        residue_d = residue_q;
        ready_d   = ready_q;
        error_d   = error_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    op_d    = opcode_t'(bus.opcode);
                    ready_d = 1'b0;
                    error_d = 1'b0;
                    if (opcode_t'(bus.opcode) == OP_RSVD) begin
                        state_d   = StDone;
                        ready_d   = 1'b1;
                        error_d   = 1'b1;
                        result_d  = '0;
                        residue_d = '0;
                    end else begin
                        state_d = StWaitX;
                    end
                end
            end
            StWaitX: begin
                if (bus.load) begin
                    x_neg_d = in_neg;
                    opa_d   = in_mag;
                    if (op_q == OP_SQRT) begin
                        if (in_neg) begin
                            state_d   = StDone;
                            ready_d   = 1'b1;
                            error_d   = 1'b1;
                            result_d  = '0;
                            residue_d = '0;
                        end else begin
                            acc_d   = {{WIDTH{1'b0}}, bus.data_in};
                            opa_d   = '0;
                            cnt_d   = CntW'(iter_count(op_q, WIDTH));
                            state_d = StCalc;
                        end
                    end else begin
                        state_d = StWaitY;
                    end
                end
            end
            StWaitY: begin
                if (bus.load) begin
                    if (op_q == OP_DIV && in_mag == '0) begin
                        state_d   = StDone;
                        ready_d   = 1'b1;
                        error_d   = 1'b1;
                        result_d  = '0;
                        residue_d = '0;
                    end else begin
                        state_d   = StCalc;
                        cnt_d     = CntW'(iter_count(op_q, WIDTH));
                        res_neg_d = x_neg_q ^ in_neg;
                        rem_neg_d = x_neg_q;
                        // MIN / -1 overflows the quotient; it still runs and wraps.
                        ovf_d     = (op_q == OP_DIV) && x_neg_q && (opa_q == MinVal)
                                    && (bus.data_in == '1);
                        if (op_q == OP_DIV) begin
                            acc_d = {{WIDTH{1'b0}}, opa_q};
                            opa_d = in_mag;
                        end else begin
                            acc_d = {{WIDTH{1'b0}}, in_mag};
                        end
                    end
                end
            end
            StCalc: begin
                acc_d = acc_it;
                opa_d = opa_it;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StDone;
                    ready_d = 1'b1;
                    case (op_q)
                        OP_MUL: {residue_d, result_d} = prod_fix;
                        OP_DIV: begin
                            result_d  = quo_fix;
                            residue_d = rem_fix;
                            error_d   = ovf_q;
                        end
                        default: begin
                            result_d  = opa_it;
                            residue_d = acc_it[W2-1:WIDTH];
                        end
                    endcase
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            op_q      <= OP_MUL;
            cnt_q     <= '0;
            acc_q     <= '0;
            opa_q     <= '0;
            x_neg_q   <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            ovf_q     <= 1'b0;
            result_q  <= '0;
            residue_q <= '0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opa_q     <= opa_d;
            x_neg_q   <= x_neg_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            ovf_q     <= ovf_d;
            result_q  <= result_d;
            residue_q <= residue_d;
            ready_q   <= ready_d;
            error_q   <= error_d;
        end
    end

    assign bus.result  = result_q;
    assign bus.residue = residue_q;
    assign bus.ready   = ready_q;
    assign bus.error   = error_q;
    assign bus.busy    = (state_q == StWaitX) || (state_q == StWaitY) || (state_q == StCalc);
    assign bus.load_x  = (state_q == StWaitX);
    assign bus.load_y  = (state_q == StWaitY);

endmodule

// File: tb/tb_msd_seq_core.sv
// Directed and random checks of msd_seq_core (WIDTH=16, SIGNED=1) against an arithmetic model.
module tb_msd_seq_core;
    localparam int unsigned WIDTH = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    msd_seq_core_if #(.WIDTH(WIDTH)) bus ();

    msd_seq_core #(.WIDTH(WIDTH), .SIGNED(1'b1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain signed integer arithmetic; lat counts cycles from the
    // final sampling cycle (load or start) to the first cycle with ready high.
    task automatic model(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                         output logic [15:0] res, output logic [15:0] rsd,
                         output logic err, output int lat);
        longint sx, sy, p, q, r, root;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        res = '0;
        rsd = '0;
        err = 1'b0;
        lat = 1;
        case (op)
            2'b00: begin
                p   = sx * sy;
                res = p[15:0];
                rsd = p[31:16];
                lat = 17;
            end
            2'b01: begin
                if (sy == 0) begin
                    err = 1'b1;
                end else if (sx == -32768 && sy == -1) begin
                    res = 16'h8000;
                    err = 1'b1;
                    lat = 17;
                end else begin
                    q   = sx / sy;
                    r   = sx % sy;
                    res = q[15:0];
                    rsd = r[15:0];
                    lat = 17;
                end
            end
            2'b10: begin
                if (sx < 0) begin
                    err = 1'b1;
                end else begin
                    root = 0;
                    while ((root + 1) * (root + 1) <= sx) root++;
                    p   = sx - root * root;
                    res = root[15:0];
                    rsd = p[15:0];
                    lat = 9;
                end
            end
            default: err = 1'b1;
        endcase
    endtask

    task automatic run_op(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                          input bit mid_start, input bit start_with_load);
        logic [15:0] er, ers;
        logic        ee;
        int          elat;
        int          cyc;
        logic        saw_ly;
        model(op, x, y, er, ers, ee, elat);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.opcode = op;
        bus.load   = start_with_load;
        bus.data_in = x;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.load    = 1'b0;
        bus.opcode  = 2'($urandom);
        bus.data_in = 16'($urandom);
        if (op != 2'b11) begin
            check1("ready_cleared", bus.ready, 1'b0);
            check1("load_x", bus.load_x, 1'b1);
            check1("busy_wait", bus.busy, 1'b1);
            bus.data_in = x;
            bus.load    = 1'b1;
            @(negedge clk);
            bus.load    = 1'b0;
            bus.data_in = 16'($urandom);
            if (op != 2'b10 && !(op == 2'b00 && 1'b0)) begin
                if (op == 2'b00 || op == 2'b01) begin
                    check1("load_y", bus.load_y, 1'b1);
                    bus.data_in = y;
                    bus.load    = 1'b1;
                    @(negedge clk);
                    bus.load    = 1'b0;
                    bus.data_in = 16'($urandom);
                end
            end
        end
        cyc    = 1;
        saw_ly = bus.load_y;
        while (!bus.ready && cyc < 64) begin
            bus.start  = mid_start && (cyc == 3);
            bus.opcode = 2'b11;
            @(negedge clk);
            cyc++;
            saw_ly = saw_ly | bus.load_y;
        end
        bus.start = 1'b0;
        check_int("latency", cyc, elat);
        check1("no_load_y_after_last", saw_ly, 1'b0);
        check1("ready", bus.ready, 1'b1);
        check1("busy_done", bus.busy, 1'b0);
        check16("result", bus.result, er);
        check16("residue", bus.residue, ers);
        check1("error", bus.error, ee);
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0:       return 16'h8000;
            1:       return 16'hFFFF;
            2:       return 16'h0000;
            3:       return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic [15:0] held;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.load    = 1'b0;
        bus.opcode  = 2'b00;
        bus.data_in = '0;
        repeat (2) @(negedge clk);
        check16("rst_result", bus.result, 16'h0000);
        check16("rst_residue", bus.residue, 16'h0000);
        check1("rst_ready", bus.ready, 1'b0);
        check1("rst_error", bus.error, 1'b0);
        check1("rst_busy", bus.busy, 1'b0);
        check1("rst_load_x", bus.load_x, 1'b0);
        check1("rst_load_y", bus.load_y, 1'b0);
        rst = 1'b0;

        run_op(2'b00, 16'd300, 16'hFF38, 1'b0, 1'b0);
        check16("mul_const_lo", bus.result, 16'h15A0);
        check16("mul_const_hi", bus.residue, 16'hFFFF);
        run_op(2'b01, 16'hFFEF, 16'd5, 1'b0, 1'b0);
        check16("div_const_q", bus.result, 16'hFFFD);
        run_op(2'b01, 16'd100, 16'd0, 1'b0, 1'b0);
        run_op(2'b10, 16'd1000, 16'd0, 1'b0, 1'b0);
        check16("sqrt_const_root", bus.result, 16'd31);
        run_op(2'b10, 16'hFFFC, 16'd0, 1'b0, 1'b0);
        run_op(2'b11, 16'd0, 16'd0, 1'b0, 1'b0);
        run_op(2'b01, 16'd8000, 16'hFFFF, 1'b1, 1'b0);
        run_op(2'b10, 16'd16, 16'd0, 1'b0, 1'b1);
        run_op(2'b01, 16'h8000, 16'hFFFF, 1'b0, 1'b0);

        // load in DONE must leave everything untouched
        held = bus.result;
        @(negedge clk);
        bus.load    = 1'b1;
        bus.data_in = 16'h1234;
        @(negedge clk);
        bus.load = 1'b0;
        check16("done_load_ignored", bus.result, held);
        check1("done_load_state", bus.load_x, 1'b0);

        // asynchronous reset in the middle of CALC
        bus.start  = 1'b1;
        bus.opcode = 2'b00;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.load    = 1'b1;
        bus.data_in = 16'd1234;
        @(negedge clk);
        bus.data_in = 16'd55;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check16("async_rst_result", bus.result, 16'h0000);
        check1("async_rst_busy", bus.busy, 1'b0);
        check1("async_rst_error", bus.error, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        run_op(2'b00, 16'd7, 16'd6, 1'b0, 1'b0);
        check16("mul_7x6", bus.result, 16'd42);

        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom_range(0, 3)), pick(), pick(), bit'($urandom_range(0, 1)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
